perceptron_seq: RTL

Stimulus sequencer and spike counter for a single perceptron_orig neuron instance. Holds up to DEPTH 8-bit stimulus words loaded over a simple write port. On start, it plays each word into the neuron as {v_in2, v_in1} for DWELL cycles, clearing the neuron between words. It counts v_out rising edges per word and hands each count out over a valid/ready result port. It sits between the top-level pin logic and the neuron.

---
 rtl/perceptron_pkg.sv | 19 +
 rtl/perceptron_seq_if.sv | 24 ++
 rtl/spike_edge_counter.sv | 42 ++++
 rtl/perceptron_seq.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/perceptron_pkg.sv
// rtl/perceptron_pkg.sv - shared FSM state type, stimulus nibble layout and default sizing
package perceptron_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_RUN,
        ST_REPORT,
        ST_FIN
    } state_t;

    localparam int NIB_W     = 4;
    localparam int V_IN1_LSB = 0;
    localparam int V_IN2_LSB = 4;

    localparam int DEF_DWELL = 16;
    localparam int DEF_CNT_W = 5;

endpackage

// File: rtl/perceptron_seq_if.sv
// rtl/perceptron_seq_if.sv - result handshake port (valid/ready with word index and spike count)
interface perceptron_seq_if #(
    parameter int IDX_W = 3,
    parameter int CNT_W = 5
);
    logic             res_valid;
    logic             res_ready;
    logic [IDX_W-1:0] res_idx;
    logic [CNT_W-1:0] res_count;

    modport master (
        output res_valid,
        output res_idx,
        output res_count,
        input  res_ready
    );

    modport slave (
        input  res_valid,
        input  res_idx,
        input  res_count,
        output res_ready
    );
endinterface

// File: rtl/spike_edge_counter.sv
// rtl/spike_edge_counter.sv - rising-edge detector feeding a saturating counter with clear
module spike_edge_counter #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             v_out_i,
    output logic [CNT_W-1:0] count_o
);
    logic             prev_q, prev_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        prev_d  = prev_q;
        count_d = count_q;
        if (clr_i) begin
            prev_d  = 1'b0;
            count_d = '0;
        end else if (en_i) begin
            prev_d = v_out_i;
            if (v_out_i && !prev_q && (count_q != {CNT_W{1'b1}})) begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q  <= 1'b0;
            count_q <= '0;
        end else begin
            prev_q  <= prev_d;
            count_q <= count_d;
        end
    end

    // Next value is exported so the final RUN sample lands in the result register on REPORT entry.
    assign count_o = count_d;

endmodule

// File: rtl/perceptron_seq.sv
// rtl/perceptron_seq.sv - plays stored stimulus words into one neuron and reports per-word spike counts
module perceptron_seq
    import perceptron_pkg::*;
#(
    parameter  int DEPTH = 8,
    parameter  int DWELL = DEF_DWELL,
    parameter  int CNT_W = DEF_CNT_W,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_addr,
    input  logic [7:0]        wr_data,
    input  logic [IDX_W:0]    len,
    input  logic              start,
    input  logic              v_out,
    output logic [3:0]        v_in1,
    output logic [3:0]        v_in2,
    output logic              neuron_rst_n,
    output logic              busy,
    output logic              done,
    perceptron_seq_if.master  res
);
    localparam int              DW_W       = $clog2(DWELL);
    localparam logic [IDX_W:0]  LEN_MAX    = (IDX_W+1)'(DEPTH);
    localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 1);

    logic [7:0]       mem_q [DEPTH];

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W:0]   len_q, len_d;
    logic [DW_W-1:0]  dwell_q, dwell_d;

    logic [3:0]       v_in1_q, v_in1_d, v_in2_q, v_in2_d;
    logic             nrst_q, nrst_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             res_valid_q, res_valid_d;
    logic [IDX_W-1:0] res_idx_q, res_idx_d;
    logic [CNT_W-1:0] res_count_q, res_count_d;

    logic [CNT_W-1:0] cnt_next;
    logic             last_word;
    logic [7:0]       word_d;

    always_ff @(posedge clk) begin
        if (wr_en && (state_q == ST_IDLE)) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    spike_edge_counter #(
        .CNT_W (CNT_W)
    ) u_spike_cnt (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (state_q == ST_CLEAR),
        .en_i    (state_q == ST_RUN),
        .v_out_i (v_out),
        .count_o (cnt_next)
    );

    assign last_word = ({1'b0, idx_q} == (len_q - 1'b1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            dwell_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            dwell_q <= dwell_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        dwell_d = '0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        state_d = ST_FIN;
                    end else begin
                        len_d   = (len > LEN_MAX) ? LEN_MAX : len;
                        idx_d   = '0;
                        state_d = ST_CLEAR;
                    end
                end
            end
            ST_CLEAR: state_d = ST_RUN;
            ST_RUN: begin
                dwell_d = dwell_q + 1'b1;
                if (dwell_q == DWELL_LAST) begin
                    state_d = ST_REPORT;
                end
            end
            ST_REPORT: begin
                if (res.res_ready) begin
                    if (last_word) begin
                        state_d = ST_FIN;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_CLEAR;
                    end
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output registers are loaded from the state being entered, so they line up with state_q.
    always_comb begin
        word_d      = mem_q[idx_d];
        v_in1_d     = v_in1_q;
        v_in2_d     = v_in2_q;
        nrst_d      = 1'b0;
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_FIN);
        res_valid_d = (state_d == ST_REPORT);
        res_idx_d   = res_idx_q;
        res_count_d = res_count_q;
        case (state_d)
            ST_CLEAR, ST_RUN: begin
                v_in1_d = word_d[V_IN1_LSB +: NIB_W];
                v_in2_d = word_d[V_IN2_LSB +: NIB_W];
                nrst_d  = (state_d == ST_RUN);
            end
            ST_REPORT: begin
                if (state_q != ST_REPORT) begin
                    res_idx_d   = idx_q;
                    res_count_d = cnt_next;
                end
            end
            default: begin
                v_in1_d = '0;
                v_in2_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v_in1_q     <= '0;
            v_in2_q     <= '0;
            nrst_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_idx_q   <= '0;
            res_count_q <= '0;
        end else begin
            v_in1_q     <= v_in1_d;
            v_in2_q     <= v_in2_d;
            nrst_q      <= nrst_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            res_valid_q <= res_valid_d;
            res_idx_q   <= res_idx_d;
            res_count_q <= res_count_d;
        end
    end

    assign v_in1         = v_in1_q;
    assign v_in2         = v_in2_q;
    assign neuron_rst_n  = nrst_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign res.res_valid = res_valid_q;
    assign res.res_idx   = res_idx_q;
    assign res.res_count = res_count_q;

endmodule
